// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external add/subtract datapath between two requesters.
// In IDLE it picks a winner. It uses round robin when both requesters ask at once.
// It latches the winner's operands and opcode onto the dp_* outputs, then captures
// dp_result and dp_carry one cycle later. The captured values go back to the
// winner with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   req[1:0]            level request per requester, held until its done bit
//   op[1:0]             per-requester opcode (0 = add, 1 = subtract)
//   a0, b0, a1, b1      requester operands (num1, num2)
//   gnt[1:0]            one-hot grant, held from latch until done
//   done[1:0]           one-cycle completion pulse to the granted requester
//   res, cout           captured datapath result and carry, held until next capture
//   busy                high whenever the sequencer is not idle
//   op_count            saturating count of completed operations
//   dp_num1, dp_num2    operands driven to the shared datapath
//   dp_sub              datapath select (0 = adder, 1 = subtractor)
//   dp_result, dp_carry combinational datapath outputs
module alu_arbiter #(
    parameter int unsigned N_WIDTH   = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [1:0]           op,
    input  logic [N_WIDTH-1:0]   a0,
    input  logic [N_WIDTH-1:0]   b0,
    input  logic [N_WIDTH-1:0]   a1,
    input  logic [N_WIDTH-1:0]   b1,
    output logic [1:0]           gnt,
    output logic [1:0]           done,
    output logic [N_WIDTH-1:0]   res,
    output logic                 cout,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] op_count,
    output logic [N_WIDTH-1:0]   dp_num1,
    output logic [N_WIDTH-1:0]   dp_num2,
    output logic                 dp_sub,
    input  logic [N_WIDTH-1:0]   dp_result,
    input  logic                 dp_carry
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state,     state_nxt;
    logic                 last_win,  last_nxt;
    logic [1:0]           gnt_nxt;
    logic [1:0]           done_nxt;
    logic [N_WIDTH-1:0]   res_nxt;
    logic                 cout_nxt;
    logic                 busy_nxt;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic [N_WIDTH-1:0]   num1_nxt;
    logic [N_WIDTH-1:0]   num2_nxt;
    logic                 sub_nxt;
    logic                 win;

    // Next-state and next-output logic; everything holds unless a state updates it.
    always_comb begin
        state_nxt = state;
        last_nxt  = last_win;
        gnt_nxt   = gnt;
        done_nxt  = 2'b00;
        res_nxt   = res;
        cout_nxt  = cout;
        busy_nxt  = busy;
        count_nxt = op_count;
        num1_nxt  = dp_num1;
        num2_nxt  = dp_num2;
        sub_nxt   = dp_sub;
        win       = 1'b0;

        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    // The last winner is only updated on ties. A lone request
                    // does not change whose turn the next tie is.
                    if (req == 2'b11) begin
                        win      = ~last_win;
                        last_nxt = ~last_win;
                    end else begin
                        win = req[1];
                    end
                    gnt_nxt   = win ? 2'b10 : 2'b01;
                    num1_nxt  = win ? a1 : a0;
                    num2_nxt  = win ? b1 : b0;
                    sub_nxt   = op[win];
                    busy_nxt  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                res_nxt   = dp_result;
                cout_nxt  = dp_carry;
                done_nxt  = gnt;
                state_nxt = DONE;
            end
            DONE: begin
                if (op_count != {CNT_WIDTH{1'b1}}) begin
                    count_nxt = op_count + CNT_WIDTH'(1);
                end
                gnt_nxt   = 2'b00;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = 2'b00;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_win <= 1'b1;
            gnt      <= 2'b00;
            done     <= 2'b00;
            res      <= '0;
            cout     <= 1'b0;
            busy     <= 1'b0;
            op_count <= '0;
            dp_num1  <= '0;
            dp_num2  <= '0;
            dp_sub   <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_win <= last_nxt;
            gnt      <= gnt_nxt;
            done     <= done_nxt;
            res      <= res_nxt;
            cout     <= cout_nxt;
            busy     <= busy_nxt;
            op_count <= count_nxt;
            dp_num1  <= num1_nxt;
            dp_num2  <= num2_nxt;
            dp_sub   <= sub_nxt;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. It models the shared add/subtract datapath
// (subtract returns magnitude, carry = non-negative). It checks every operation
// against an arithmetic reference that tracks round-robin turns and the
// saturating op counter.
module tb_alu_arbiter;

    localparam int unsigned NW   = 4;
    localparam int unsigned CW   = 8;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req;
    logic [1:0]    op;
    logic [NW-1:0] a0, b0, a1, b1;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic [NW-1:0] res;
    logic          cout;
    logic          busy;
    logic [CW-1:0] op_count;
    logic [NW-1:0] dp_num1, dp_num2;
    logic          dp_sub;
    logic [NW-1:0] dp_result;
    logic          dp_carry;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic tb_last;
    int   tb_count;

    alu_arbiter #(.N_WIDTH(NW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .done(done), .res(res), .cout(cout), .busy(busy),
        .op_count(op_count), .dp_num1(dp_num1), .dp_num2(dp_num2),
        .dp_sub(dp_sub), .dp_result(dp_result), .dp_carry(dp_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared datapath: adder, or magnitude subtractor with carry = (num1 >= num2).
    always_comb begin
        dp_result = '0;
        dp_carry  = 1'b0;
        if (!dp_sub) begin
            {dp_carry, dp_result} = {1'b0, dp_num1} + {1'b0, dp_num2};
        end else if (dp_num1 >= dp_num2) begin
            dp_result = dp_num1 - dp_num2;
            dp_carry  = 1'b1;
        end else begin
            dp_result = dp_num2 - dp_num1;
            dp_carry  = 1'b0;
        end
    end

    // Reference result {carry, result} from plain integer arithmetic.
    function automatic logic [NW:0] ref_alu(input logic s, input int x, input int y);
        int v;
        if (!s) begin
            v = x + y;
            return {1'(v >= (1 << NW)), NW'(v % (1 << NW))};
        end else if (x >= y) begin
            return {1'b1, NW'(x - y)};
        end else begin
            return {1'b0, NW'(y - x)};
        end
    endfunction

    // Reference arbitration: lone request wins; a tie goes to whoever did not win the last tie.
    task automatic model_pick(input logic [1:0] r, output logic w);
        if (r == 2'b11) begin
            w       = ~tb_last;
            tb_last = w;
        end else begin
            w = r[1];
        end
    endtask

    task automatic model_done();
        if (tb_count < CMAX) tb_count++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        tb_last  = 1'b1;
        tb_count = 0;
    endtask

    // Drive one request and observe grant/done. Latencies are counted in edges from driving req.
    task automatic run_op(input logic [1:0] r, input logic keep,
                          output logic [1:0] g, output logic [1:0] d,
                          output logic [NW-1:0] rv, output logic cv,
                          output int lg, output int ld,
                          output logic [1:0] d_after, output logic bz);
        g = 2'b00; d = 2'b00; rv = '0; cv = 1'b0;
        lg = -1; ld = -1; d_after = 2'b11; bz = 1'b0;
        req = r;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (lg < 0 && gnt != 2'b00) begin
                g  = gnt;
                lg = k;
                bz = busy;
            end
            if (done != 2'b00) begin
                d  = done;
                rv = res;
                cv = cout;
                ld = k;
                break;
            end
        end
        if (!keep) req = 2'b00;
        @(posedge clk);
        #1;
        d_after = done;
    endtask

    task automatic test_reset();
        logic [1:0] g, d, da;
        logic [NW-1:0] rv;
        logic cv, bz, w;
        int lg, ld;
        op = 2'b00; a0 = 4'd1; b0 = 4'd2; a1 = 4'd3; b1 = 4'd4;
        rst_n = 1'b0;
        req   = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({gnt, done, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: gnt=%b done=%b busy=%b, expected 00 00 0", gnt, done, busy);
        end
        n_tests++;
        if ({res, cout, op_count, dp_num1, dp_num2, dp_sub} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: res=%0d cout=%b cnt=%0d dp=%0d/%0d/%b, expected all 0",
                     res, cout, op_count, dp_num1, dp_num2, dp_sub);
        end
        rst_n    = 1'b1;
        tb_last  = 1'b1;
        tb_count = 0;
        model_pick(2'b11, w);
        run_op(2'b11, 1'b0, g, d, rv, cv, lg, ld, da, bz);
        model_done();
        n_tests++;
        if (g !== 2'b01 || w !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_tie: gnt=%b, expected 01", g);
        end
    endtask

    task automatic test_single_add();
        logic [1:0] g, d, da;
        logic [NW-1:0] rv;
        logic cv, bz;
        int lg, ld;
        do_reset();
        op = 2'b00; a0 = 4'd5; b0 = 4'd3;
        run_op(2'b01, 1'b0, g, d, rv, cv, lg, ld, da, bz);
        model_done();
        n_tests++;
        if (g !== 2'b01 || lg != 1 || bz !== 1'b1) begin
            n_fail++;
            $display("FAIL add_grant: gnt=%b at edge %0d busy=%b, expected 01 at edge 1 busy=1", g, lg, bz);
        end
        n_tests++;
        if (d !== 2'b01 || ld != 2 || da !== 2'b00) begin
            n_fail++;
            $display("FAIL add_done: done=%b at edge %0d then %b, expected 01 at edge 2 then 00", d, ld, da);
        end
        n_tests++;
        if (rv !== 4'd8 || cv !== 1'b0) begin
            n_fail++;
            $display("FAIL add_result: res=%0d cout=%b, expected 8 0", rv, cv);
        end
        n_tests++;
        if (op_count !== CW'(1) || busy !== 1'b0 || gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL add_after: cnt=%0d busy=%b gnt=%b, expected 1 0 00", op_count, busy, gnt);
        end
    endtask

    task automatic test_subtract();
        logic [1:0] g, d, da;
        logic [NW-1:0] rv;
        logic cv, bz;
        int lg, ld;
        op = 2'b10; a1 = 4'd7; b1 = 4'd2;
        run_op(2'b10, 1'b0, g, d, rv, cv, lg, ld, da, bz);
        model_done();
        n_tests++;
        if (g !== 2'b10 || d !== 2'b10 || rv !== 4'd5 || cv !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_pos: gnt=%b done=%b res=%0d cout=%b, expected 10 10 5 1", g, d, rv, cv);
        end
        a1 = 4'd2; b1 = 4'd7;
        run_op(2'b10, 1'b0, g, d, rv, cv, lg, ld, da, bz);
        model_done();
        n_tests++;
        if (g !== 2'b10 || d !== 2'b10 || rv !== 4'd5 || cv !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_neg: gnt=%b done=%b res=%0d cout=%b, expected 10 10 5 0", g, d, rv, cv);
        end
        n_tests++;
        if (op_count !== CW'(tb_count)) begin
            n_fail++;
            $display("FAIL sub_count: cnt=%0d, expected %0d", op_count, tb_count);
        end
    endtask

    task automatic test_contention();
        logic [1:0] g, d, da, eg;
        logic [NW-1:0] rv;
        logic [NW:0] e;
        logic cv, bz, w;
        int lg, ld;
        do_reset();
        op = 2'b10; a0 = 4'd9; b0 = 4'd9; a1 = 4'd3; b1 = 4'd11;
        for (int i = 0; i < 4; i++) begin
            model_pick(2'b11, w);
            eg = w ? 2'b10 : 2'b01;
            e  = ref_alu(op[w], w ? int'(a1) : int'(a0), w ? int'(b1) : int'(b0));
            run_op(2'b11, 1'b1, g, d, rv, cv, lg, ld, da, bz);
            model_done();
            n_tests++;
            if ({g, d, cv, rv} !== {eg, eg, e} || lg != 1 || ld != 2) begin
                n_fail++;
                $display("FAIL contention[%0d]: gnt=%b done=%b cout=%b res=%0d lat=%0d/%0d, expected %b %b %b %0d 1/2",
                         i, g, d, cv, rv, lg, ld, eg, eg, e[NW], e[NW-1:0]);
            end
        end
        req = 2'b00;
        n_tests++;
        if (op_count !== CW'(4)) begin
            n_fail++;
            $display("FAIL contention_count: cnt=%0d, expected 4", op_count);
        end
    endtask

    task automatic test_operand_change();
        op = 2'b00; a0 = 4'd5; b0 = 4'd3;
        req = 2'b01;
        @(posedge clk);
        #1;
        a0 = 4'd9; b0 = 4'd0;
        @(posedge clk);
        #1;
        n_tests++;
        if (done !== 2'b01 || res !== 4'd8 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL operand_hold: done=%b res=%0d cout=%b, expected 01 8 0", done, res, cout);
        end
        req = 2'b00;
        @(posedge clk);
        #1;
        model_done();
        n_tests++;
        if (op_count !== CW'(tb_count)) begin
            n_fail++;
            $display("FAIL operand_count: cnt=%0d, expected %0d", op_count, tb_count);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        op = 2'b00; a1 = 4'd4; b1 = 4'd4;
        req = 2'b10;
        @(posedge clk);
        #1;
        n_tests++;
        if (gnt !== 2'b10 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_grant: gnt=%b busy=%b, expected 10 1", gnt, busy);
        end
        rst_n = 1'b0;
        req   = 2'b00;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        tb_last  = 1'b1;
        tb_count = 0;
        n_tests++;
        if ({gnt, done, busy} !== 5'b0 || op_count !== CW'(0) || res !== '0) begin
            n_fail++;
            $display("FAIL abort_state: gnt=%b done=%b busy=%b cnt=%0d res=%0d, expected 00 00 0 0 0",
                     gnt, done, busy, op_count, res);
        end
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (done != 2'b00 || busy) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d active cycles after abort, expected 0", pulses);
        end
    endtask

    task automatic test_random();
        logic [1:0] g, d, da, eg, r;
        logic [NW-1:0] rv;
        logic [NW:0] e;
        logic cv, bz, w;
        int lg, ld;
        for (int i = 0; i < 24; i++) begin
            r  = 2'($urandom_range(3, 1));
            op = 2'($urandom);
            a0 = NW'($urandom); b0 = NW'($urandom);
            a1 = NW'($urandom); b1 = NW'($urandom);
            model_pick(r, w);
            eg = w ? 2'b10 : 2'b01;
            e  = ref_alu(op[w], w ? int'(a1) : int'(a0), w ? int'(b1) : int'(b0));
            run_op(r, 1'b0, g, d, rv, cv, lg, ld, da, bz);
            model_done();
            n_tests++;
            if ({g, d, cv, rv} !== {eg, eg, e} || lg != 1 || ld != 2 || da !== 2'b00) begin
                n_fail++;
                $display("FAIL random[%0d] req=%b: gnt=%b done=%b cout=%b res=%0d lat=%0d/%0d, expected %b %b %b %0d 1/2",
                         i, r, g, d, cv, rv, lg, ld, eg, eg, e[NW], e[NW-1:0]);
            end
        end
        n_tests++;
        if (op_count !== CW'(tb_count)) begin
            n_fail++;
            $display("FAIL random_count: cnt=%0d, expected %0d", op_count, tb_count);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] g, d, da;
        logic [NW-1:0] rv;
        logic cv, bz, w;
        int lg, ld;
        do_reset();
        op = 2'b00; a0 = 4'd1; b0 = 4'd1; a1 = 4'd2; b1 = 4'd2;
        for (int i = 0; i < CMAX; i++) begin
            model_pick(2'b11, w);
            run_op(2'b11, 1'b1, g, d, rv, cv, lg, ld, da, bz);
            model_done();
        end
        req = 2'b00;
        n_tests++;
        if (op_count !== CW'(CMAX) || tb_count != CMAX) begin
            n_fail++;
            $display("FAIL sat_preload: cnt=%0d, expected %0d", op_count, CMAX);
        end
        op = 2'b00; a0 = 4'd15; b0 = 4'd1;
        run_op(2'b01, 1'b0, g, d, rv, cv, lg, ld, da, bz);
        model_done();
        n_tests++;
        if (d !== 2'b01 || rv !== 4'd0 || cv !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_wrap_add: done=%b res=%0d cout=%b, expected 01 0 1", d, rv, cv);
        end
        n_tests++;
        if (op_count !== CW'(CMAX)) begin
            n_fail++;
            $display("FAIL sat_hold: cnt=%0d, expected %0d", op_count, CMAX);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        op    = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tb_last  = 1'b1;
        tb_count = 0;
        test_reset();
        test_single_add();
        test_subtract();
        test_contention();
        test_operand_change();
        test_reset_abort();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
